// File: rtl/vending_ctrl_param.sv
// Parameterised vending controller: IDLE -> PAY -> VEND/REFUND -> IDLE, one-cycle vend/change/soldout pulses.
// Decisions take effect on the next edge; there is no backpressure, every input is sampled only in the state that uses it.
module vending_ctrl_param #(
    parameter int                     ITEMS      = 4,
    parameter int                     MW         = 8,
    parameter logic [ITEMS*MW-1:0]    PRICES     = {8'd10, 8'd2, 8'd5, 8'd7},
    parameter int                     STOCK_W    = 4,
    parameter int                     STOCK_INIT = 3,
    parameter int                     TIMEOUT    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(ITEMS)-1:0]   item_sel,
    input  logic                       coin_valid,
    input  logic [MW-1:0]              coin_val,
    input  logic                       cancel,
    input  logic                       restock,
    output logic [1:0]                 state,
    output logic [MW-1:0]              balance,
    output logic                       vend,
    output logic [$clog2(ITEMS)-1:0]   vend_item,
    output logic                       change_valid,
    output logic [MW-1:0]              change,
    output logic                       err_soldout,
    output logic                       busy
);
    localparam int IW = $clog2(ITEMS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PAY    = 2'd1,
        S_VEND   = 2'd2,
        S_REFUND = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [IW-1:0]        r_item;
    logic [MW-1:0]        r_price;
    logic [MW-1:0]        r_balance;
    logic [STOCK_W-1:0]   r_stock [ITEMS];
    logic [TW-1:0]        r_tmr;
    logic                 r_err;

    logic [MW:0]          w_sum;
    logic [MW-1:0]        w_bal_coin;
    logic [STOCK_W-1:0]   w_sel_stock;
    logic                 w_start_ok;

    always_comb begin
        w_sum       = {1'b0, r_balance} + {1'b0, coin_val};
        w_bal_coin  = w_sum[MW] ? {MW{1'b1}} : w_sum[MW-1:0];
        // restock lands first, so a simultaneous start sees the reloaded count
        w_sel_stock = restock ? STOCK_W'(STOCK_INIT) : r_stock[item_sel];
        w_start_ok  = start && (w_sel_stock != '0);

        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_PAY;
            end
            S_PAY: begin
                if (cancel)
                    w_next = S_REFUND;
                else if (coin_valid && (w_bal_coin >= r_price))
                    w_next = S_VEND;
                else if (!coin_valid && (r_tmr == TW'(TIMEOUT - 1)))
                    w_next = S_REFUND;
            end
            S_VEND:   w_next = S_IDLE;
            S_REFUND: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_item    <= '0;
            r_price   <= '0;
            r_balance <= '0;
            r_tmr     <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (restock)
                        for (int i = 0; i < ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
                    if (w_start_ok) begin
                        r_item    <= item_sel;
                        r_price   <= PRICES[item_sel*MW +: MW];
                        r_balance <= '0;
                        r_tmr     <= '0;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                S_PAY: begin
                    if (coin_valid) begin
                        r_balance <= w_bal_coin;
                        r_tmr     <= '0;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_VEND: begin
                    if (r_stock[r_item] != '0) r_stock[r_item] <= r_stock[r_item] - STOCK_W'(1);
                    r_balance <= '0;
                end
                default: r_balance <= '0;
            endcase
        end
    end

    always_comb begin
        state        = r_state;
        balance      = r_balance;
        busy         = (r_state != S_IDLE);
        vend         = (r_state == S_VEND);
        vend_item    = r_item;
        err_soldout  = r_err;
        change_valid = 1'b0;
        change       = '0;
        if (r_state == S_VEND) begin
            change_valid = (r_balance != r_price);
            change       = r_balance - r_price;
        end else if (r_state == S_REFUND) begin
            change_valid = (r_balance != '0);
            change       = r_balance;
        end
    end
endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: directed scenarios plus randomized transactions vs a transaction-level model.
module tb_vending_ctrl_param;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 0, coin_valid = 0, cancel = 0, restock = 0;
    logic [1:0] item_sel = 0;
    logic [7:0] coin_val = 0;
    logic [1:0] state, vend_item;
    logic [7:0] balance, change;
    logic       vend, change_valid, err_soldout, busy;

    logic       s_start = 0, s_coin_valid = 0, s_cancel = 0, s_restock = 0;
    logic [1:0] s_item_sel = 0;
    logic [7:0] s_coin_val = 0;
    logic [1:0] s_state, s_vend_item;
    logic [7:0] s_balance, s_change;
    logic       s_vend, s_change_valid, s_err_soldout, s_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int price [4] = '{7, 5, 2, 10};
    int exp_stock [4] = '{3, 3, 3, 3};

    always #5 clk = ~clk;

    vending_ctrl_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .item_sel(item_sel),
        .coin_valid(coin_valid), .coin_val(coin_val), .cancel(cancel), .restock(restock),
        .state(state), .balance(balance), .vend(vend), .vend_item(vend_item),
        .change_valid(change_valid), .change(change), .err_soldout(err_soldout), .busy(busy)
    );

    // item0 costs 255 (saturation), item3 costs 0 (free item)
    vending_ctrl_param #(.PRICES({8'd0, 8'd9, 8'd9, 8'd255})) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .item_sel(s_item_sel),
        .coin_valid(s_coin_valid), .coin_val(s_coin_val), .cancel(s_cancel), .restock(s_restock),
        .state(s_state), .balance(s_balance), .vend(s_vend), .vend_item(s_vend_item),
        .change_valid(s_change_valid), .change(s_change), .err_soldout(s_err_soldout), .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic buy(input int it, input int cv);
        item_sel = 2'(it); start = 1; tick(); start = 0;
        coin_valid = 1; coin_val = 8'(cv); tick(); coin_valid = 0;
        tick();
        if (cv >= price[it]) exp_stock[it] = exp_stock[it] - 1;
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1; coin_valid = 1; coin_val = 8'd9; cancel = 1;
        tick(); tick();
        start = 0; coin_valid = 0; cancel = 0; rst_n = 1;
        n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_tests++; if (balance !== 8'd0) begin n_fail++; $display("FAIL reset_balance got=%0d exp=0", balance); end
        n_tests++; if ({vend, change_valid, err_soldout, busy} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {vend, change_valid, err_soldout, busy}); end
        n_tests++; if (change !== 8'd0) begin n_fail++; $display("FAIL reset_change got=%0d exp=0", change); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (dut.r_stock[i] !== 4'd3) begin n_fail++; $display("FAIL reset_stock%0d got=%0d exp=3", i, dut.r_stock[i]); end
        end
    endtask

    task automatic test_vend_change();
        item_sel = 0; start = 1; tick(); start = 0;
        n_tests++; if (state !== 2'd1 || balance !== 8'd0) begin n_fail++; $display("FAIL vc_enter_pay state=%0d bal=%0d exp 1/0", state, balance); end
        coin_valid = 1; coin_val = 8'd5; tick();
        n_tests++; if (state !== 2'd1 || balance !== 8'd5) begin n_fail++; $display("FAIL vc_coin1 state=%0d bal=%0d exp 1/5", state, balance); end
        tick(); coin_valid = 0;
        n_tests++; if (vend !== 1'b1 || vend_item !== 2'd0 || change_valid !== 1'b1 || change !== 8'd3) begin
            n_fail++; $display("FAIL vc_vend vend=%b item=%0d cv=%b chg=%0d exp 1/0/1/3", vend, vend_item, change_valid, change); end
        tick(); exp_stock[0] = 2;
        n_tests++; if (state !== 2'd0 || vend !== 1'b0 || change_valid !== 1'b0 || balance !== 8'd0) begin
            n_fail++; $display("FAIL vc_after state=%0d vend=%b cv=%b bal=%0d exp 0/0/0/0", state, vend, change_valid, balance); end
        n_tests++; if (dut.r_stock[0] !== 4'd2) begin n_fail++; $display("FAIL vc_stock0 got=%0d exp=2", dut.r_stock[0]); end
    endtask

    task automatic test_exact();
        item_sel = 2; start = 1; tick(); start = 0;
        coin_valid = 1; coin_val = 8'd2; tick(); coin_valid = 0;
        n_tests++; if (vend !== 1'b1 || vend_item !== 2'd2 || change_valid !== 1'b0) begin
            n_fail++; $display("FAIL exact_vend vend=%b item=%0d cv=%b exp 1/2/0", vend, vend_item, change_valid); end
        tick(); exp_stock[2] = 2;
        n_tests++; if (state !== 2'd0 || vend !== 1'b0) begin n_fail++; $display("FAIL exact_idle state=%0d vend=%b exp 0/0", state, vend); end
    endtask

    task automatic test_cancel();
        item_sel = 1; start = 1; tick(); start = 0;
        coin_valid = 1; coin_val = 8'd4; tick(); coin_valid = 0;
        cancel = 1; tick(); cancel = 0;
        n_tests++; if (state !== 2'd3 || change_valid !== 1'b1 || change !== 8'd4 || vend !== 1'b0) begin
            n_fail++; $display("FAIL cancel_refund state=%0d cv=%b chg=%0d vend=%b exp 3/1/4/0", state, change_valid, change, vend); end
        tick();
        n_tests++; if (state !== 2'd0 || change_valid !== 1'b0 || dut.r_stock[1] !== 4'd3) begin
            n_fail++; $display("FAIL cancel_after state=%0d cv=%b stock1=%0d exp 0/0/3", state, change_valid, dut.r_stock[1]); end
    endtask

    task automatic test_soldout();
        for (int k = 0; k < 3; k++) buy(3, 10);
        n_tests++; if (dut.r_stock[3] !== 4'd0) begin n_fail++; $display("FAIL so_stock3 got=%0d exp=0", dut.r_stock[3]); end
        item_sel = 3; start = 1; tick(); start = 0;
        n_tests++; if (state !== 2'd0 || err_soldout !== 1'b1) begin n_fail++; $display("FAIL so_err state=%0d err=%b exp 0/1", state, err_soldout); end
        tick();
        n_tests++; if (err_soldout !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL so_err_pulse err=%b state=%0d exp 0/0", err_soldout, state); end
        restock = 1; start = 1; tick(); restock = 0; start = 0;
        for (int i = 0; i < 4; i++) exp_stock[i] = 3;
        n_tests++; if (state !== 2'd1 || err_soldout !== 1'b0) begin n_fail++; $display("FAIL so_restock_start state=%0d err=%b exp 1/0", state, err_soldout); end
        cancel = 1; tick(); cancel = 0;
        n_tests++; if (state !== 2'd3 || change_valid !== 1'b0) begin n_fail++; $display("FAIL so_zero_refund state=%0d cv=%b exp 3/0", state, change_valid); end
        tick();
        n_tests++; if (dut.r_stock[3] !== 4'd3) begin n_fail++; $display("FAIL so_stock_reload got=%0d exp=3", dut.r_stock[3]); end
    endtask

    task automatic test_timeout();
        int early = 0;
        item_sel = 0; start = 1; tick(); start = 0;
        coin_valid = 1; coin_val = 8'd3; tick(); coin_valid = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (state !== 2'd1) early++;
        end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL to_early left_pay_cycles=%0d exp=0", early); end
        tick();
        n_tests++; if (state !== 2'd3 || change_valid !== 1'b1 || change !== 8'd3) begin
            n_fail++; $display("FAIL to_refund state=%0d cv=%b chg=%0d exp 3/1/3", state, change_valid, change); end
        tick();
        n_tests++; if (state !== 2'd0 || dut.r_stock[0] !== 4'(exp_stock[0])) begin
            n_fail++; $display("FAIL to_after state=%0d stock0=%0d exp 0/%0d", state, dut.r_stock[0], exp_stock[0]); end
    endtask

    task automatic test_reset_midtx();
        int seen_cv = 0;
        item_sel = 0; start = 1; tick(); start = 0;
        coin_valid = 1; coin_val = 8'd5; tick(); coin_valid = 0;
        rst_n = 0; cancel = 1; @(posedge clk); #1;
        if (change_valid) seen_cv++;
        rst_n = 1; cancel = 0;
        tick();
        if (change_valid) seen_cv++;
        for (int i = 0; i < 4; i++) exp_stock[i] = 3;
        n_tests++; if (state !== 2'd0 || balance !== 8'd0 || seen_cv != 0) begin
            n_fail++; $display("FAIL rst_mid state=%0d bal=%0d cv_cycles=%0d exp 0/0/0", state, balance, seen_cv); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (dut.r_stock[i] !== 4'd3) begin n_fail++; $display("FAIL rst_mid_stock%0d got=%0d exp=3", i, dut.r_stock[i]); end
        end
    endtask

    task automatic test_saturate_free();
        s_item_sel = 0; s_start = 1; tick(); s_start = 0;
        s_coin_valid = 1; s_coin_val = 8'd200; tick();
        n_tests++; if (s_state !== 2'd1 || s_balance !== 8'd200) begin n_fail++; $display("FAIL sat_coin1 state=%0d bal=%0d exp 1/200", s_state, s_balance); end
        s_coin_val = 8'd100; tick(); s_coin_valid = 0;
        n_tests++; if (s_state !== 2'd2 || s_balance !== 8'd255 || s_change_valid !== 1'b0) begin
            n_fail++; $display("FAIL sat_bal state=%0d bal=%0d cv=%b exp 2/255/0", s_state, s_balance, s_change_valid); end
        tick();
        s_item_sel = 3; s_start = 1; tick(); s_start = 0;
        n_tests++; if (s_state !== 2'd1) begin n_fail++; $display("FAIL free_pay state=%0d exp=1", s_state); end
        s_coin_valid = 1; s_coin_val = 8'd6; tick(); s_coin_valid = 0;
        n_tests++; if (s_vend !== 1'b1 || s_vend_item !== 2'd3 || s_change_valid !== 1'b1 || s_change !== 8'd6) begin
            n_fail++; $display("FAIL free_vend vend=%b item=%0d cv=%b chg=%0d exp 1/3/1/6", s_vend, s_vend_item, s_change_valid, s_change); end
        tick();
    endtask

    // Transaction-level model: a purchase ends in a vend (balance reaches price),
    // a refund (cancel or 16 quiet cycles), or a soldout error.
    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int  it = $urandom_range(3, 0);
            bit  rs = ($urandom_range(5, 0) == 0);
            int  bal = 0;
            bit  done = 0;
            item_sel = 2'(it); start = 1; restock = rs; tick(); start = 0; restock = 0;
            if (rs) for (int i = 0; i < 4; i++) exp_stock[i] = 3;
            if (exp_stock[it] == 0) begin
                n_tests++; if (state !== 2'd0 || err_soldout !== 1'b1) begin n_fail++; $display("FAIL rnd_soldout t=%0d state=%0d err=%b exp 0/1", t, state, err_soldout); end
                tick();
                continue;
            end
            n_tests++; if (state !== 2'd1 || balance !== 8'd0) begin n_fail++; $display("FAIL rnd_pay t=%0d state=%0d bal=%0d exp 1/0", t, state, balance); end
            while (!done) begin
                int act = $urandom_range(9, 0);
                if (act == 0) begin
                    for (int k = 0; k < 16; k++) begin
                        start = $urandom_range(1, 0); restock = $urandom_range(1, 0); tick();
                    end
                    start = 0; restock = 0;
                end else begin
                    int gap = $urandom_range(3, 0);
                    int cv  = $urandom_range(6, 0);
                    for (int g = 0; g < gap; g++) begin
                        start = $urandom_range(1, 0); restock = $urandom_range(1, 0); tick();
                    end
                    start = 0; restock = 0;
                    coin_valid = (act != 1) || ($urandom_range(1, 0) == 1);
                    coin_val = 8'(cv); cancel = (act == 1);
                    tick();
                    if (coin_valid) bal = (bal + cv > 255) ? 255 : bal + cv;
                    coin_valid = 0; cancel = 0;
                end
                if (act <= 1) begin
                    n_tests++; if (state !== 2'd3 || vend !== 1'b0 || change_valid !== (bal != 0) || (bal != 0 && change !== 8'(bal))) begin
                        n_fail++; $display("FAIL rnd_refund t=%0d state=%0d vend=%b cv=%b chg=%0d exp 3/0/%0d/%0d", t, state, vend, change_valid, change, bal != 0, bal); end
                    done = 1;
                end else if (bal >= price[it]) begin
                    n_tests++; if (vend !== 1'b1 || vend_item !== 2'(it) || change_valid !== (bal != price[it]) || (bal != price[it] && change !== 8'(bal - price[it]))) begin
                        n_fail++; $display("FAIL rnd_vend t=%0d vend=%b item=%0d cv=%b chg=%0d exp 1/%0d/%0d/%0d", t, vend, vend_item, change_valid, change, it, bal != price[it], bal - price[it]); end
                    exp_stock[it] = exp_stock[it] - 1;
                    done = 1;
                end else begin
                    n_tests++; if (state !== 2'd1 || balance !== 8'(bal)) begin n_fail++; $display("FAIL rnd_bal t=%0d state=%0d bal=%0d exp 1/%0d", t, state, balance, bal); end
                end
            end
            coin_valid = $urandom_range(1, 0); coin_val = 8'd9; cancel = $urandom_range(1, 0);
            tick();
            coin_valid = 0; cancel = 0;
            n_tests++; if (state !== 2'd0 || balance !== 8'd0 || dut.r_stock[it] !== 4'(exp_stock[it])) begin
                n_fail++; $display("FAIL rnd_end t=%0d state=%0d bal=%0d stock=%0d exp 0/0/%0d", t, state, balance, dut.r_stock[it], exp_stock[it]); end
        end
    endtask

    initial begin
        test_reset();
        test_vend_change();
        test_exact();
        test_cancel();
        test_soldout();
        test_timeout();
        test_reset_midtx();
        test_saturate_free();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
